// File: rtl/alsu_pkg.sv
// Shared types and helpers for the pipelined ALSU.
package alsu_pkg;

  typedef enum logic [2:0] {
    OP_OR     = 3'd0,
    OP_XOR    = 3'd1,
    OP_ADD    = 3'd2,
    OP_MULT   = 3'd3,
    OP_SHIFT  = 3'd4,
    OP_ROTATE = 3'd5,
    OP_INV6   = 3'd6,
    OP_INV7   = 3'd7
  } opcode_e;

  typedef enum logic {
    BL_IDLE  = 1'b0,
    BL_BLINK = 1'b1
  } blink_state_e;

  localparam int PRIO_A = 0;
  localparam int PRIO_B = 1;

  // Reductions are only meaningful for OR/XOR; anything else with a reduction bit is rejected.
  function automatic logic is_invalid(input opcode_e op, input logic red_a, input logic red_b);
    return (op == OP_INV6) || (op == OP_INV7) ||
           ((red_a || red_b) && (op != OP_OR) && (op != OP_XOR));
  endfunction

endpackage

// File: rtl/alsu_pipe_if.sv
// Request/response bundle between the operand source and the ALSU pipeline.
interface alsu_pipe_if #(parameter int WIDTH = 8);
  localparam int SW = $clog2(WIDTH);

  logic                      in_valid;
  logic                      in_ready;
  logic signed [WIDTH-1:0]   A;
  logic signed [WIDTH-1:0]   B;
  logic [2:0]                opcode;
  logic                      cin;
  logic                      serial_in;
  logic                      direction;
  logic [SW-1:0]             shamt;
  logic                      red_op_A;
  logic                      red_op_B;
  logic                      bypass_A;
  logic                      bypass_B;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*WIDTH-1:0]        out;
  logic                      invalid;

  modport master (
    output in_valid, A, B, opcode, cin, serial_in, direction, shamt,
           red_op_A, red_op_B, bypass_A, bypass_B, out_ready,
    input  in_ready, out_valid, out, invalid
  );

  modport slave (
    input  in_valid, A, B, opcode, cin, serial_in, direction, shamt,
           red_op_A, red_op_B, bypass_A, bypass_B, out_ready,
    output in_ready, out_valid, out, invalid
  );
endinterface

// File: rtl/alsu_led_blinker.sv
// LED blink sequencer: each trigger (re)starts a run of timed all-on/all-off phases.
module alsu_led_blinker
  import alsu_pkg::*;
#(
  parameter int BLINK_PERIOD = 4,
  parameter int BLINK_PULSES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  output logic [15:0] leds
);

  localparam logic [15:0] PERIOD_LAST = 16'(BLINK_PERIOD - 1);
  localparam logic [15:0] LAST_TOGGLE = 16'(2 * BLINK_PULSES - 2);

  blink_state_e state, state_n;
  logic [15:0]  period_cnt, period_cnt_n;
  logic [15:0]  toggle_cnt, toggle_cnt_n;
  logic [15:0]  leds_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BL_IDLE;
      period_cnt <= '0;
      toggle_cnt <= '0;
      leds       <= '0;
    end else begin
      state      <= state_n;
      period_cnt <= period_cnt_n;
      toggle_cnt <= toggle_cnt_n;
      leds       <= leds_n;
    end
  end

  // The final inversion forces the LEDs dark and ends the run.
  always_comb begin
    state_n      = state;
    period_cnt_n = period_cnt;
    toggle_cnt_n = toggle_cnt;
    leds_n       = leds;
    if (trigger) begin
      state_n      = BL_BLINK;
      period_cnt_n = '0;
      toggle_cnt_n = '0;
      leds_n       = 16'hFFFF;
    end else begin
      case (state)
        BL_BLINK: begin
          if (period_cnt == PERIOD_LAST) begin
            period_cnt_n = '0;
            if (toggle_cnt == LAST_TOGGLE) begin
              toggle_cnt_n = '0;
              leds_n       = '0;
              state_n      = BL_IDLE;
            end else begin
              toggle_cnt_n = toggle_cnt + 16'd1;
              leds_n       = ~leds;
            end
          end else begin
            period_cnt_n = period_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/alsu_pipe.sv
// Two-stage ALSU: S1 captures the request, S2 computes and holds the result under backpressure.
module alsu_pipe
  import alsu_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int INPUT_PRIORITY = 0,
  parameter int FULL_ADDER     = 1,
  parameter int BLINK_PERIOD   = 4,
  parameter int BLINK_PULSES   = 3
) (
  input  logic        clk,
  input  logic        rst,
  alsu_pipe_if.slave  bus,
  output logic [15:0] leds,
  output logic [15:0] err_count
);

  localparam int OW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH);

  logic                    s1_v, s2_v, s1_adv, s2_adv, fire;
  logic signed [WIDTH-1:0] s1_a, s1_b;
  opcode_e                 s1_op;
  logic                    s1_cin, s1_serial, s1_dir;
  logic                    s1_red_a, s1_red_b, s1_byp_a, s1_byp_b;
  logic [SW-1:0]           s1_shamt;
  logic [OW-1:0]           out_q, result;
  logic                    invalid_q, result_inv;

  assign s2_adv        = !s2_v || bus.out_ready;
  assign s1_adv        = !s1_v || s2_adv;
  assign bus.in_ready  = s1_adv && !rst;
  assign bus.out_valid = s2_v;
  assign bus.out       = out_q;
  assign bus.invalid   = invalid_q;
  assign fire          = s2_v && bus.out_ready && invalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= OP_OR;
      s1_cin    <= 1'b0;
      s1_serial <= 1'b0;
      s1_dir    <= 1'b0;
      s1_shamt  <= '0;
      s1_red_a  <= 1'b0;
      s1_red_b  <= 1'b0;
      s1_byp_a  <= 1'b0;
      s1_byp_b  <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a      <= bus.A;
        s1_b      <= bus.B;
        s1_op     <= opcode_e'(bus.opcode);
        s1_cin    <= bus.cin;
        s1_serial <= bus.serial_in;
        s1_dir    <= bus.direction;
        s1_shamt  <= bus.shamt;
        s1_red_a  <= bus.red_op_A;
        s1_red_b  <= bus.red_op_B;
        s1_byp_a  <= bus.bypass_A;
        s1_byp_b  <= bus.bypass_B;
      end
    end
  end

  logic [OW-1:0]        ext_a, ext_b, ones, fill_low, fill_high, shifted, rotated;
  logic signed [OW-1:0] prod;
  logic [WIDTH-1:0]     red_opnd;
  logic                 red_pick_a, byp_pick_a, cin_eff;
  int                   rot_back;

  assign ext_a = {{WIDTH{s1_a[WIDTH-1]}}, s1_a};
  assign ext_b = {{WIDTH{s1_b[WIDTH-1]}}, s1_b};
  assign ones  = {OW{1'b1}};

  // SHIFT/ROTATE operate on the last computed result still sitting in the S2 register.
  always_comb begin
    red_pick_a = s1_red_a && (!s1_red_b || INPUT_PRIORITY == PRIO_A);
    byp_pick_a = s1_byp_a && (!s1_byp_b || INPUT_PRIORITY != PRIO_B);
    red_opnd   = red_pick_a ? s1_a : s1_b;
    cin_eff    = (FULL_ADDER != 0) && s1_cin;
    prod       = $signed(ext_a) * $signed(ext_b);
    fill_low   = s1_serial ? ~(ones << s1_shamt) : '0;
    fill_high  = s1_serial ? ~(ones >> s1_shamt) : '0;
    rot_back   = OW - int'(s1_shamt);
    shifted    = s1_dir ? ((out_q << s1_shamt) | fill_low) : ((out_q >> s1_shamt) | fill_high);
    rotated    = s1_dir ? ((out_q << s1_shamt) | (out_q >> rot_back))
                        : ((out_q >> s1_shamt) | (out_q << rot_back));
    result     = '0;
    result_inv = 1'b0;
    if (s1_byp_a || s1_byp_b) begin
      result = byp_pick_a ? ext_a : ext_b;
    end else if (is_invalid(s1_op, s1_red_a, s1_red_b)) begin
      result_inv = 1'b1;
    end else begin
      case (s1_op)
        OP_OR:     result = (s1_red_a || s1_red_b) ? {{(OW-1){1'b0}}, |red_opnd}
                                                   : {{WIDTH{1'b0}}, s1_a | s1_b};
        OP_XOR:    result = (s1_red_a || s1_red_b) ? {{(OW-1){1'b0}}, ^red_opnd}
                                                   : {{WIDTH{1'b0}}, s1_a ^ s1_b};
        OP_ADD:    result = ext_a + ext_b + {{(OW-1){1'b0}}, cin_eff};
        OP_MULT:   result = prod;
        OP_SHIFT:  result = shifted;
        OP_ROTATE: result = rotated;
        default:   result = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v      <= 1'b0;
      out_q     <= '0;
      invalid_q <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_q     <= result;
        invalid_q <= result_inv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (fire && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

  alsu_led_blinker #(
    .BLINK_PERIOD (BLINK_PERIOD),
    .BLINK_PULSES (BLINK_PULSES)
  ) u_blinker (
    .clk     (clk),
    .rst     (rst),
    .trigger (fire),
    .leds    (leds)
  );

endmodule

// File: tb/tb_alsu_pipe.sv
// Bench for alsu_pipe: directed scenarios plus random traffic against a queue-based reference model.
module tb_alsu_pipe;

  localparam int BP     = 4;
  localparam int PULSES = 3;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sin;
    logic       dir;
    logic [2:0] sh;
    logic       ra;
    logic       rb;
    logic       ba;
    logic       bb;
  } req_t;

  typedef struct packed {
    logic [15:0] res;
    logic        inv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] leds;
  logic [15:0] err_count;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   trig_cyc = 0;
  bit   blink_on = 0;
  int   err_model = 0;
  bit   rand_done = 0;
  logic [15:0] prev_model = '0;
  exp_t expq[$];

  alsu_pipe_if #(.WIDTH(8)) bus();

  alsu_pipe #(
    .WIDTH          (8),
    .INPUT_PRIORITY (0),
    .FULL_ADDER     (1),
    .BLINK_PERIOD   (BP),
    .BLINK_PULSES   (PULSES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .leds      (leds),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic and bit-at-a-time shifting.
  function automatic exp_t refModel(input req_t r, input logic [15:0] prev);
    exp_t       e;
    int         sa, sb;
    logic [15:0] v;
    logic [7:0] opnd;
    sa    = int'($signed(r.a));
    sb    = int'($signed(r.b));
    e.res = 16'h0;
    e.inv = 1'b0;
    v     = prev;
    if (r.ba || r.bb) begin
      e.res = r.ba ? 16'(sa) : 16'(sb);
    end else if (r.op >= 3'd6 || ((r.ra || r.rb) && r.op > 3'd1)) begin
      e.inv = 1'b1;
    end else begin
      case (r.op)
        3'd0, 3'd1: begin
          if (r.ra || r.rb) begin
            opnd = r.ra ? r.a : r.b;
            if (r.op == 3'd0) e.res = ($countones(opnd) != 0) ? 16'd1 : 16'd0;
            else              e.res = ($countones(opnd) % 2 == 1) ? 16'd1 : 16'd0;
          end else begin
            e.res = (r.op == 3'd0) ? {8'h00, r.a | r.b} : {8'h00, r.a ^ r.b};
          end
        end
        3'd2: e.res = 16'(sa + sb + int'(r.cin));
        3'd3: e.res = 16'(sa * sb);
        3'd4: begin
          for (int k = 0; k < int'(r.sh); k++) v = r.dir ? {v[14:0], r.sin} : {r.sin, v[15:1]};
          e.res = v;
        end
        default: begin
          for (int k = 0; k < int'(r.sh); k++) v = r.dir ? {v[14:0], v[15]} : {v[0], v[15:1]};
          e.res = v;
        end
      endcase
    end
    return e;
  endfunction

  function automatic req_t opReq(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_t r;
    r    = '0;
    r.op = op;
    r.a  = a;
    r.b  = b;
    return r;
  endfunction

  task automatic driveReq(input req_t r);
    bus.opcode    = r.op;
    bus.A         = r.a;
    bus.B         = r.b;
    bus.cin       = r.cin;
    bus.serial_in = r.sin;
    bus.direction = r.dir;
    bus.shamt     = r.sh;
    bus.red_op_A  = r.ra;
    bus.red_op_B  = r.rb;
    bus.bypass_A  = r.ba;
    bus.bypass_B  = r.bb;
    bus.in_valid  = 1'b1;
  endtask

  task automatic applyStimulus(input req_t r);
    bit done;
    done = 0;
    driveReq(r);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic expectResult(input string tag, input logic [15:0] eout, input logic einv, output int lat);
    bit seen;
    seen = 0;
    lat  = -1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        seen = 1;
        lat  = i;
      end
    end
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "_out"}, 32'(bus.out), 32'(eout));
      checkOutput({tag, "_inv"}, 32'(bus.invalid), 32'(einv));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: predicts at acceptance, compares at delivery, tracks LEDs and error count.
  initial forever begin
    req_t        cur;
    exp_t        e;
    logic [15:0] led_exp;
    int          el;
    @(negedge clk);
    if (rst) begin
      expq.delete();
      prev_model = '0;
      err_model  = 0;
      blink_on   = 0;
    end else begin
      led_exp = 16'h0;
      if (blink_on) begin
        el = cyc - trig_cyc;
        if (el >= BP * (2 * PULSES - 1)) blink_on = 0;
        else if ((el / BP) % 2 == 0) led_exp = 16'hFFFF;
      end
      checkOutput("leds", 32'(leds), 32'(led_exp));
      checkOutput("err_count", 32'(err_count), 32'(err_model));
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          checkOutput("sb_out", 32'(bus.out), 32'(e.res));
          checkOutput("sb_invalid", 32'(bus.invalid), 32'(e.inv));
          if (e.inv) begin
            if (err_model < 65535) err_model++;
            trig_cyc = cyc + 1;
            blink_on = 1;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        cur.op  = bus.opcode;
        cur.a   = bus.A;
        cur.b   = bus.B;
        cur.cin = bus.cin;
        cur.sin = bus.serial_in;
        cur.dir = bus.direction;
        cur.sh  = bus.shamt;
        cur.ra  = bus.red_op_A;
        cur.rb  = bus.red_op_B;
        cur.ba  = bus.bypass_A;
        cur.bb  = bus.bypass_B;
        e = refModel(cur, prev_model);
        expq.push_back(e);
        prev_model = e.res;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_t r;
    int   lat;
    bit   rdy [3];
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    driveReq('0);
    bus.in_valid = 1'b0;

    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out", 32'(bus.out), 32'd0);
    checkOutput("rst_leds", 32'(leds), 32'd0);
    checkOutput("rst_err", 32'(err_count), 32'd0);
    doReset();

    r = opReq(3'd2, 8'd100, 8'd50);
    r.cin = 1'b1;
    applyStimulus(r);
    expectResult("add", 16'd151, 1'b0, lat);
    checkOutput("add_latency", 32'(lat), 32'd1);

    applyStimulus(opReq(3'd3, 8'hFD, 8'd7));
    expectResult("mult", 16'hFFEB, 1'b0, lat);
    r = opReq(3'd2, 8'd5, 8'd6);
    r.ra = 1'b1;
    applyStimulus(r);
    expectResult("red_inv", 16'h0000, 1'b1, lat);

    applyStimulus(opReq(3'd2, 8'd1, 8'd0));
    expectResult("seed", 16'h0001, 1'b0, lat);
    r = opReq(3'd4, 8'd0, 8'd0);
    r.dir = 1'b1; r.sh = 3'd3; r.sin = 1'b1;
    applyStimulus(r);
    expectResult("shift", 16'h000F, 1'b0, lat);
    r = opReq(3'd5, 8'd0, 8'd0);
    r.dir = 1'b0; r.sh = 3'd4;
    applyStimulus(r);
    expectResult("rotate", 16'hF000, 1'b0, lat);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      driveReq(opReq(3'd2, 8'(10 * (i + 1)), 8'd1));
      @(negedge clk);
      rdy[i] = bus.in_ready;
      @(posedge clk);
      #1;
    end
    checkOutput("bp_accept0", 32'(rdy[0]), 32'd1);
    checkOutput("bp_accept1", 32'(rdy[1]), 32'd1);
    checkOutput("bp_stall", 32'(rdy[2]), 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_ready_low", 32'(bus.in_ready), 32'd0);
      checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_hold_out", 32'(bus.out), 32'd11);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    applyStimulus(opReq(3'd2, 8'd30, 8'd1));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp_drained", 32'(expq.size()), 32'd0);

    doReset();
    applyStimulus(opReq(3'd6, 8'd0, 8'd0));
    expectResult("blink_inv", 16'h0, 1'b1, lat);
    checkOutput("blink_on", 32'(leds), 32'hFFFF);
    checkOutput("blink_err1", 32'(err_count), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("blink_invert", 32'(leds), 32'h0);
    applyStimulus(opReq(3'd7, 8'd0, 8'd0));
    expectResult("blink_inv2", 16'h0, 1'b1, lat);
    checkOutput("blink_restart", 32'(leds), 32'hFFFF);
    checkOutput("blink_err2", 32'(err_count), 32'd2);
    repeat (16) @(posedge clk);
    #1;
    checkOutput("blink_extended", 32'(leds), 32'hFFFF);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("blink_done", 32'(leds), 32'h0);

    applyStimulus(opReq(3'd6, 8'd0, 8'd0));
    expectResult("pre_rst_inv", 16'h0, 1'b1, lat);
    bus.out_ready = 1'b0;
    applyStimulus(opReq(3'd2, 8'd1, 8'd2));
    applyStimulus(opReq(3'd2, 8'd3, 8'd4));
    checkOutput("full_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("full_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_out", 32'(bus.out), 32'd0);
    checkOutput("mid_rst_leds", 32'(leds), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd0);

    r = opReq(3'd7, 8'h80, 8'h11);
    r.ba = 1'b1; r.bb = 1'b1;
    applyStimulus(r);
    expectResult("bypass", 16'hFF80, 1'b0, lat);
    checkOutput("bypass_err", 32'(err_count), 32'd0);

    fork
      begin
        for (int n = 0; n < 400; n++) begin
          r     = '0;
          r.op  = 3'($urandom_range(0, 7));
          r.a   = 8'($urandom);
          r.b   = 8'($urandom);
          r.cin = 1'($urandom);
          r.sin = 1'($urandom);
          r.dir = 1'($urandom);
          r.sh  = 3'($urandom);
          r.ra  = ($urandom_range(0, 5) == 0);
          r.rb  = ($urandom_range(0, 5) == 0);
          r.ba  = ($urandom_range(0, 7) == 0);
          r.bb  = ($urandom_range(0, 7) == 0);
          applyStimulus(r);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("rand_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
